// File: rtl/sumador_monitor_if.sv
// Bundles the nets shared by the adder DUT, its probador and the response monitor.
// master drives the operands and the DUT response; slave (the monitor) only observes them.
interface sumador_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             RCI;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic [WIDTH-1:0] EXP_Q;
  logic             EXP_RCO;
  logic             ERR;
  logic             FAIL;
  logic [CNT_W-1:0] CHK_CNT;
  logic [CNT_W-1:0] ERR_CNT;

  modport master (
    output ENB, MODO, A, B, RCI, Q, RCO,
    input  EXP_Q, EXP_RCO, ERR, FAIL, CHK_CNT, ERR_CNT
  );

  modport slave (
    input  ENB, MODO, A, B, RCI, Q, RCO,
    output EXP_Q, EXP_RCO, ERR, FAIL, CHK_CNT, ERR_CNT
  );
endinterface

// File: rtl/sumador_monitor.sv
// Response checker for the registered adder family: a cycle-accurate reference model
// compared every edge against the DUT's Q/RCO, with sticky fail and saturating counters.
module sumador_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET_L,
  sumador_monitor_if.slave   mon
);

  localparam logic [0:0] S_WAIT  = 1'b0;
  localparam logic [0:0] S_CHECK = 1'b1;

  logic [0:0]       state_r;
  logic [WIDTH-1:0] exp_q_r;
  logic             exp_rco_r;
  logic             err_r;
  logic             fail_r;
  logic [CNT_W-1:0] chk_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic [WIDTH:0]   next_s;
  logic             mismatch_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next value of the reference model; borrow of the subtraction lands in the top bit.
  always_comb begin
    sum_s  = {1'b0, mon.A} + {1'b0, mon.B} + {{WIDTH{1'b0}}, mon.RCI};
    dif_s  = {1'b0, mon.A} - {1'b0, mon.B} - {{WIDTH{1'b0}}, mon.RCI};
    next_s = {exp_rco_r, exp_q_r};
    if (mon.ENB) begin
      case (mon.MODO)
        2'b00:   next_s = sum_s;
        2'b01:   next_s = dif_s;
        2'b10:   next_s = {exp_rco_r, exp_q_r};
        2'b11:   next_s = {(WIDTH+1){1'b0}};
        default: next_s = {exp_rco_r, exp_q_r};
      endcase
    end else begin
      next_s = {exp_rco_r, exp_q_r};
    end
  end

  // Four-state compare so that an undriven or unknown DUT output is flagged.
  always_comb begin
    mismatch_s = ({mon.RCO, mon.Q} !== {exp_rco_r, exp_q_r});
  end

  // Reference model register.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      exp_q_r   <= {WIDTH{1'b0}};
      exp_rco_r <= 1'b0;
    end else begin
      {exp_rco_r, exp_q_r} <= next_s;
    end
  end

  // Checker FSM: compares the pre-update model, so the load edge itself is never checked.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_r   <= S_WAIT;
      err_r     <= 1'b0;
      fail_r    <= 1'b0;
      chk_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_WAIT: begin
          err_r <= 1'b0;
          if (mon.ENB && (mon.MODO != 2'b10)) begin
            state_r <= S_CHECK;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_CHECK: begin
          chk_cnt_r <= sat_inc(chk_cnt_r);
          if (mismatch_s) begin
            err_r     <= 1'b1;
            fail_r    <= 1'b1;
            err_cnt_r <= sat_inc(err_cnt_r);
          end else begin
            err_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_WAIT;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign mon.EXP_Q   = exp_q_r;
  assign mon.EXP_RCO = exp_rco_r;
  assign mon.ERR     = err_r;
  assign mon.FAIL    = fail_r;
  assign mon.CHK_CNT = chk_cnt_r;
  assign mon.ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_sumador_monitor.sv
// Directed bench for sumador_monitor: the bench plays the adder DUT by driving hand-computed
// Q/RCO values; a second instance with 2-bit counters covers saturation.
module tb_sumador_monitor;

  logic clk;
  logic reset_l;
  int   tests;
  int   fails;

  sumador_monitor_if #(.WIDTH(8), .CNT_W(16)) bus_main ();
  sumador_monitor_if #(.WIDTH(8), .CNT_W(2))  bus_sat ();

  sumador_monitor #(.WIDTH(8), .CNT_W(16)) dut_main (
    .CLK     (clk),
    .RESET_L (reset_l),
    .mon     (bus_main)
  );

  sumador_monitor #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .CLK     (clk),
    .RESET_L (reset_l),
    .mon     (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_main(input logic enb, input logic [1:0] modo, input logic [7:0] a,
                            input logic [7:0] b, input logic rci, input logic [7:0] q,
                            input logic rco);
    bus_main.ENB = enb;  bus_main.MODO = modo; bus_main.A = a; bus_main.B = b;
    bus_main.RCI = rci;  bus_main.Q = q;       bus_main.RCO = rco;
  endtask

  task automatic drive_sat(input logic enb, input logic [1:0] modo, input logic [7:0] a,
                           input logic [7:0] b, input logic rci, input logic [7:0] q,
                           input logic rco);
    bus_sat.ENB = enb;  bus_sat.MODO = modo; bus_sat.A = a; bus_sat.B = b;
    bus_sat.RCI = rci;  bus_sat.Q = q;       bus_sat.RCO = rco;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    drive_main(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    drive_sat(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    tests++; if (bus_main.EXP_Q !== 8'h00) begin fails++; $display("FAIL reset_exp_q got %h want 00", bus_main.EXP_Q); end
    tests++; if (bus_main.EXP_RCO !== 1'b0) begin fails++; $display("FAIL reset_exp_rco got %b want 0", bus_main.EXP_RCO); end
    tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus_main.ERR); end
    tests++; if (bus_main.FAIL !== 1'b0) begin fails++; $display("FAIL reset_fail got %b want 0", bus_main.FAIL); end
    tests++; if (bus_main.CHK_CNT !== 16'd0) begin fails++; $display("FAIL reset_chk_cnt got %0d want 0", bus_main.CHK_CNT); end
    tests++; if (bus_main.ERR_CNT !== 16'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", bus_main.ERR_CNT); end
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_hold_window();
    drive_main(1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tests++; if (bus_main.CHK_CNT !== 16'd0) begin fails++; $display("FAIL load_edge_no_check got %0d want 0", bus_main.CHK_CNT); end
    bus_main.MODO = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL hold_err cycle %0d got %b want 0", i, bus_main.ERR); end
    end
    tests++; if (bus_main.CHK_CNT !== 16'd5) begin fails++; $display("FAIL hold_chk_cnt got %0d want 5", bus_main.CHK_CNT); end
    tests++; if (bus_main.ERR_CNT !== 16'd0) begin fails++; $display("FAIL hold_err_cnt got %0d want 0", bus_main.ERR_CNT); end
    tests++; if (bus_main.FAIL !== 1'b0) begin fails++; $display("FAIL hold_fail got %b want 0", bus_main.FAIL); end
  endtask

  task automatic test_sum();
    drive_main(1'b1, 2'b00, 8'hF0, 8'h20, 1'b1, 8'h00, 1'b0);
    tick();
    tests++; if (bus_main.EXP_Q !== 8'h11) begin fails++; $display("FAIL sum_exp_q got %h want 11", bus_main.EXP_Q); end
    tests++; if (bus_main.EXP_RCO !== 1'b1) begin fails++; $display("FAIL sum_exp_rco got %b want 1", bus_main.EXP_RCO); end
    tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL sum_err got %b want 0", bus_main.ERR); end
    drive_main(1'b1, 2'b10, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1);
    tick();
    tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL sum_dut_ok_err got %b want 0", bus_main.ERR); end
    tests++; if (bus_main.CHK_CNT !== 16'd7) begin fails++; $display("FAIL sum_chk_cnt got %0d want 7", bus_main.CHK_CNT); end
  endtask

  task automatic test_error();
    bus_main.Q = 8'h00;
    tick();
    tests++; if (bus_main.ERR !== 1'b1) begin fails++; $display("FAIL err_pulse got %b want 1", bus_main.ERR); end
    tests++; if (bus_main.ERR_CNT !== 16'd1) begin fails++; $display("FAIL err_cnt got %0d want 1", bus_main.ERR_CNT); end
    tests++; if (bus_main.FAIL !== 1'b1) begin fails++; $display("FAIL err_fail_set got %b want 1", bus_main.FAIL); end
    bus_main.Q = 8'h11;
    tick();
    tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL err_one_cycle got %b want 0", bus_main.ERR); end
    tests++; if (bus_main.FAIL !== 1'b1) begin fails++; $display("FAIL fail_sticky got %b want 1", bus_main.FAIL); end
    tests++; if (bus_main.ERR_CNT !== 16'd1) begin fails++; $display("FAIL err_cnt_after got %0d want 1", bus_main.ERR_CNT); end
    tests++; if (bus_main.CHK_CNT !== 16'd9) begin fails++; $display("FAIL err_chk_cnt got %0d want 9", bus_main.CHK_CNT); end
  endtask

  task automatic test_enb_off();
    logic [7:0] a_v;
    logic [1:0] m_v;
    for (int i = 0; i < 4; i++) begin
      a_v = 8'h30 + 8'(i);
      m_v = 2'(i);
      drive_main(1'b0, m_v, a_v, 8'h5A - 8'(i), 1'(i), 8'h11, 1'b1);
      tick();
      tests++; if (bus_main.EXP_Q !== 8'h11) begin fails++; $display("FAIL enb_off_exp_q cycle %0d got %h want 11", i, bus_main.EXP_Q); end
      tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL enb_off_err cycle %0d got %b want 0", i, bus_main.ERR); end
    end
    tests++; if (bus_main.EXP_RCO !== 1'b1) begin fails++; $display("FAIL enb_off_exp_rco got %b want 1", bus_main.EXP_RCO); end
    tests++; if (bus_main.CHK_CNT !== 16'd13) begin fails++; $display("FAIL enb_off_chk_cnt got %0d want 13", bus_main.CHK_CNT); end
  endtask

  task automatic test_sub();
    drive_main(1'b1, 2'b01, 8'h05, 8'h07, 1'b0, 8'h11, 1'b1);
    tick();
    tests++; if (bus_main.EXP_Q !== 8'hFE) begin fails++; $display("FAIL sub_exp_q got %h want fe", bus_main.EXP_Q); end
    tests++; if (bus_main.EXP_RCO !== 1'b1) begin fails++; $display("FAIL sub_borrow got %b want 1", bus_main.EXP_RCO); end
    drive_main(1'b1, 2'b01, 8'h10, 8'h0F, 1'b1, 8'hFE, 1'b1);
    tick();
    tests++; if (bus_main.EXP_Q !== 8'h00) begin fails++; $display("FAIL sub_rci_exp_q got %h want 00", bus_main.EXP_Q); end
    tests++; if (bus_main.EXP_RCO !== 1'b0) begin fails++; $display("FAIL sub_rci_exp_rco got %b want 0", bus_main.EXP_RCO); end
    tests++; if (bus_main.ERR !== 1'b0) begin fails++; $display("FAIL sub_err got %b want 0", bus_main.ERR); end
    drive_main(1'b1, 2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
    tick();
    tests++; if (bus_main.EXP_Q !== 8'h00) begin fails++; $display("FAIL wrap_exp_q got %h want 00", bus_main.EXP_Q); end
    tests++; if (bus_main.EXP_RCO !== 1'b1) begin fails++; $display("FAIL wrap_exp_rco got %b want 1", bus_main.EXP_RCO); end
    // Q agrees with the model; only the carry disagrees.
    drive_main(1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tests++; if (bus_main.ERR !== 1'b1) begin fails++; $display("FAIL rco_only_err got %b want 1", bus_main.ERR); end
    tests++; if (bus_main.ERR_CNT !== 16'd2) begin fails++; $display("FAIL rco_only_err_cnt got %0d want 2", bus_main.ERR_CNT); end
    tests++; if (bus_main.CHK_CNT !== 16'd17) begin fails++; $display("FAIL sub_chk_cnt got %0d want 17", bus_main.CHK_CNT); end
  endtask

  task automatic test_saturation();
    logic [1:0] want_v;
    drive_sat(1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tests++; if (bus_sat.CHK_CNT !== 2'd0) begin fails++; $display("FAIL sat_load_chk got %0d want 0", bus_sat.CHK_CNT); end
    drive_sat(1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      want_v = (i >= 2) ? 2'd3 : 2'(i + 1);
      tests++; if (bus_sat.ERR !== 1'b1) begin fails++; $display("FAIL sat_err_pulse %0d got %b want 1", i, bus_sat.ERR); end
      tests++; if (bus_sat.ERR_CNT !== want_v) begin fails++; $display("FAIL sat_err_cnt %0d got %0d want %0d", i, bus_sat.ERR_CNT, want_v); end
    end
    tests++; if (bus_sat.CHK_CNT !== 2'd3) begin fails++; $display("FAIL sat_chk_cnt got %0d want 3", bus_sat.CHK_CNT); end
    tests++; if (bus_sat.FAIL !== 1'b1) begin fails++; $display("FAIL sat_fail got %b want 1", bus_sat.FAIL); end
    @(negedge clk);
    #2;
    reset_l = 1'b0;
    #1;
    tests++; if (bus_sat.ERR_CNT !== 2'd0) begin fails++; $display("FAIL mid_reset_err_cnt got %0d want 0", bus_sat.ERR_CNT); end
    tests++; if (bus_sat.CHK_CNT !== 2'd0) begin fails++; $display("FAIL mid_reset_chk_cnt got %0d want 0", bus_sat.CHK_CNT); end
    tests++; if (bus_sat.FAIL !== 1'b0) begin fails++; $display("FAIL mid_reset_fail got %b want 0", bus_sat.FAIL); end
    tests++; if (bus_sat.ERR !== 1'b0) begin fails++; $display("FAIL mid_reset_err got %b want 0", bus_sat.ERR); end
    tests++; if (bus_main.FAIL !== 1'b0) begin fails++; $display("FAIL mid_reset_main_fail got %b want 0", bus_main.FAIL); end
    tests++; if (bus_main.ERR_CNT !== 16'd0) begin fails++; $display("FAIL mid_reset_main_err_cnt got %0d want 0", bus_main.ERR_CNT); end
    @(negedge clk);
    reset_l = 1'b1;
    // Hold mode cannot leave S_WAIT, so this mismatching Q must be ignored.
    drive_sat(1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0);
    tick();
    tests++; if (bus_sat.ERR !== 1'b0) begin fails++; $display("FAIL wait_no_err got %b want 0", bus_sat.ERR); end
    tests++; if (bus_sat.CHK_CNT !== 2'd0) begin fails++; $display("FAIL wait_no_chk got %0d want 0", bus_sat.CHK_CNT); end
    drive_sat(1'b1, 2'b00, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    tick();
    tests++; if (bus_sat.CHK_CNT !== 2'd0) begin fails++; $display("FAIL rewait_load_chk got %0d want 0", bus_sat.CHK_CNT); end
    tests++; if (bus_sat.EXP_Q !== 8'h03) begin fails++; $display("FAIL rewait_exp_q got %h want 03", bus_sat.EXP_Q); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_hold_window();
    test_sum();
    test_error();
    test_enb_off();
    test_sub();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
